// File: rtl/hazard_stall_controller_pkg.sv
// hazard_stall_controller_pkg
//   Shared types and constants for the pipeline hazard scheduler:
//   FSM state encoding, scoreboard slot layout, the zero-register
//   specifier and the stall lengths for each hazard class.
package hazard_stall_controller_pkg;

  // Scoreboard destination width; instances must use REG_ADDR_W equal to this.
  localparam int unsigned SB_DEST_W = 5;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hsc_state_t;

  typedef struct packed {
    logic [SB_DEST_W-1:0] dest;
    logic                 load;
  } sb_slot_t;

  localparam logic [SB_DEST_W-1:0] REG_ZERO = '0;
  localparam sb_slot_t             SB_EMPTY = '0;

  localparam logic [1:0] LOAD_USE_STALL = 2'd1;
  localparam logic [1:0] BR_ALU_STALL   = 2'd1;
  localparam logic [1:0] BR_LOAD_STALL  = 2'd2;

endpackage

// File: rtl/hazard_stall_controller_need_calc.sv
// hazard_need_calc
//   Purely combinational: number of stall cycles the ID instruction needs
//   before its operands can be forwarded, given the in-flight scoreboard.
// Ports:
//   id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_branch : ID fields
//   sb_exe, sb_mem, sb_wb : scoreboard slots {dest, load}
//   need  : 0..2 stall cycles required
module hazard_need_calc
  import hazard_stall_controller_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_branch,
  input  sb_slot_t              sb_exe,
  input  sb_slot_t              sb_mem,
  input  sb_slot_t              sb_wb,
  output logic [1:0]            need
);

  function automatic logic src_hit(input logic                  used,
                                   input logic [REG_ADDR_W-1:0] src,
                                   input sb_slot_t              slot);
    return used && (src != REG_ZERO) && (src == slot.dest);
  endfunction

  logic hit_exe, hit_mem, hit_wb;
  // WB results are always forwardable; only the dest participates in matching.
  logic unused_wb_load;

  assign hit_exe = src_hit(id_uses_rs, id_rs, sb_exe) | src_hit(id_uses_rt, id_rt, sb_exe);
  assign hit_mem = src_hit(id_uses_rs, id_rs, sb_mem) | src_hit(id_uses_rt, id_rt, sb_mem);
  assign hit_wb  = src_hit(id_uses_rs, id_rs, sb_wb)  | src_hit(id_uses_rt, id_rt, sb_wb);
  assign unused_wb_load = sb_wb.load;

  // Checks are ordered from the largest requirement down, so the first
  // match taken is the maximum over both sources.
  always_comb begin
    need = '0;
    if (id_valid) begin
      if (id_branch) begin
        if (hit_exe && sb_exe.load)      need = BR_LOAD_STALL;
        else if (hit_exe)                need = BR_ALU_STALL;
        else if (hit_mem && sb_mem.load) need = LOAD_USE_STALL;
        else if (hit_wb)                 need = '0;
      end else begin
        if (hit_exe && sb_exe.load)      need = LOAD_USE_STALL;
      end
    end
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
//   Hazard scheduler for the 5-stage MIPS core. Tracks destinations in
//   flight (EXE/MEM/WB), stalls ID for load-use and branch/JR hazards that
//   forwarding cannot cover, and drives the PC, IF/ID and ID/EXE enables.
// Ports:
//   CLK, RESET (async, active low)
//   ID_* : decoded fields of the instruction in ID; FLUSH squashes it
//   PC_Write_En, IFID_Write_En, IDEXE_Bubble, Stall (= !PC_Write_En)
//   Stall_Cycles, Load_Use_Events : statistics, live only when the
//   HAZARD_STATS_EN macro is defined, otherwise tied to zero.
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned STAT_W     = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  ID_Valid,
  input  logic [REG_ADDR_W-1:0] ID_rs,
  input  logic [REG_ADDR_W-1:0] ID_rt,
  input  logic                  ID_uses_rs,
  input  logic                  ID_uses_rt,
  input  logic                  ID_branch,
  input  logic                  ID_reg_write,
  input  logic [REG_ADDR_W-1:0] ID_dest,
  input  logic                  ID_load,
  input  logic                  FLUSH,
  output logic                  PC_Write_En,
  output logic                  IFID_Write_En,
  output logic                  IDEXE_Bubble,
  output logic                  Stall,
  output logic [STAT_W-1:0]     Stall_Cycles,
  output logic [STAT_W-1:0]     Load_Use_Events
);

  hsc_state_t state_q;
  logic [1:0] cnt_q;
  sb_slot_t   sb_exe_q, sb_mem_q, sb_wb_q;
  logic [1:0] need;

  hazard_need_calc #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_need_calc (
    .id_valid   (ID_Valid),
    .id_rs      (ID_rs),
    .id_rt      (ID_rt),
    .id_uses_rs (ID_uses_rs),
    .id_uses_rt (ID_uses_rt),
    .id_branch  (ID_branch),
    .sb_exe     (sb_exe_q),
    .sb_mem     (sb_mem_q),
    .sb_wb      (sb_wb_q),
    .need       (need)
  );

  // Enables respond to need in the same cycle; RESET is folded in so the
  // outputs show the run values for the whole time reset is held.
  always_comb begin
    PC_Write_En   = 1'b1;
    IFID_Write_En = 1'b1;
    IDEXE_Bubble  = 1'b0;
    if (RESET) begin
      if (FLUSH) begin
        IDEXE_Bubble = 1'b1;
      end else if (state_q == STALL || need != 2'd0) begin
        PC_Write_En   = 1'b0;
        IFID_Write_En = 1'b0;
        IDEXE_Bubble  = 1'b1;
      end
    end
  end

  assign Stall = ~PC_Write_En;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      sb_exe_q <= SB_EMPTY;
      sb_mem_q <= SB_EMPTY;
      sb_wb_q  <= SB_EMPTY;
    end else begin
      sb_wb_q  <= sb_mem_q;
      sb_mem_q <= sb_exe_q;
      if (!IDEXE_Bubble && ID_Valid && ID_reg_write)
        sb_exe_q <= '{dest: ID_dest, load: ID_load};
      else
        sb_exe_q <= SB_EMPTY;

      if (FLUSH) begin
        state_q <= RUN;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          RUN: begin
            // need=1 clears by itself next cycle; only longer stalls hold state.
            if (need > 2'd1) begin
              state_q <= STALL;
              cnt_q   <= need - 2'd1;
            end
          end
          STALL: begin
            if (cnt_q <= 2'd1) begin
              state_q <= RUN;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q - 2'd1;
            end
          end
          default: begin
            state_q <= RUN;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_cycles_q, load_use_events_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      stall_cycles_q    <= '0;
      load_use_events_q <= '0;
    end else begin
      if (Stall)
        stall_cycles_q <= stall_cycles_q + 1'b1;
      if (state_q == RUN && need != 2'd0 && !FLUSH)
        load_use_events_q <= load_use_events_q + 1'b1;
    end
  end

  assign Stall_Cycles    = stall_cycles_q;
  assign Load_Use_Events = load_use_events_q;
`else
  assign Stall_Cycles    = '0;
  assign Load_Use_Events = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller
//   Directed scenarios followed by randomized instruction streams, all
//   checked against a distance-based reference model of operand readiness.
module tb_hazard_stall_controller;

  localparam int unsigned RW = 5;
  localparam int unsigned SW = 32;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          ID_Valid = 1'b0;
  logic [RW-1:0] ID_rs = '0, ID_rt = '0, ID_dest = '0;
  logic          ID_uses_rs = 1'b0, ID_uses_rt = 1'b0, ID_branch = 1'b0;
  logic          ID_reg_write = 1'b0, ID_load = 1'b0, FLUSH = 1'b0;
  logic          PC_Write_En, IFID_Write_En, IDEXE_Bubble, Stall;
  logic [SW-1:0] Stall_Cycles, Load_Use_Events;

  hazard_stall_controller #(
    .REG_ADDR_W(RW),
    .STAT_W    (SW)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .ID_Valid       (ID_Valid),
    .ID_rs          (ID_rs),
    .ID_rt          (ID_rt),
    .ID_uses_rs     (ID_uses_rs),
    .ID_uses_rt     (ID_uses_rt),
    .ID_branch      (ID_branch),
    .ID_reg_write   (ID_reg_write),
    .ID_dest        (ID_dest),
    .ID_load        (ID_load),
    .FLUSH          (FLUSH),
    .PC_Write_En    (PC_Write_En),
    .IFID_Write_En  (IFID_Write_En),
    .IDEXE_Bubble   (IDEXE_Bubble),
    .Stall          (Stall),
    .Stall_Cycles   (Stall_Cycles),
    .Load_Use_Events(Load_Use_Events)
  );

  always #5 CLK = ~CLK;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: each in-flight producer sits at distance d (1 = one
  // instruction ahead). A value is usable by a consumer at distance >= req,
  // where req depends on producer kind and whether the consumer needs it in ID.
  typedef struct packed {
    logic [RW-1:0] dest;
    logic          load;
  } ent_t;

  ent_t        hist[$];
  int          stall_left = 0;
  int          m_need;
  logic        m_pc, m_ifid, m_bub;
  logic [31:0] m_cycles = '0, m_events = '0;
  int unsigned ep_stalls = 0;

  function automatic int model_need();
    int best = 0;
    int req;
    if (!ID_Valid) return 0;
    for (int d = 1; d <= hist.size(); d++) begin
      ent_t e = hist[d-1];
      if (e.dest != 0 && ((ID_uses_rs && ID_rs == e.dest) || (ID_uses_rt && ID_rt == e.dest))) begin
        req = ID_branch ? (e.load ? 3 : 2) : (e.load ? 2 : 1);
        if (req - d > best) best = req - d;
      end
    end
    return best;
  endfunction

  task automatic model_outputs();
    m_need = model_need();
    m_pc = 1'b1; m_ifid = 1'b1; m_bub = 1'b0;
    if (RESET) begin
      if (FLUSH) m_bub = 1'b1;
      else if (stall_left > 0 || m_need > 0) begin
        m_pc = 1'b0; m_ifid = 1'b0; m_bub = 1'b1;
      end
    end
  endtask

  task automatic model_advance();
    ent_t e;
    if (!m_pc) m_cycles++;
    if (stall_left == 0 && m_need > 0 && !FLUSH) m_events++;
    e = '0;
    if (!m_bub && ID_Valid && ID_reg_write) e = '{dest: ID_dest, load: ID_load};
    hist.push_front(e);
    if (hist.size() > 3) void'(hist.pop_back());
    if (FLUSH) stall_left = 0;
    else if (stall_left > 0) stall_left--;
    else if (m_need > 0) stall_left = m_need - 1;
  endtask

  task automatic model_reset();
    hist.delete();
    stall_left = 0;
    m_cycles = '0;
    m_events = '0;
  endtask

  // Called 1ns after a rising edge: compare at the falling edge, then advance.
  task automatic cycle(input string tag);
    #4;
    model_outputs();
    chk({tag, "_pc"},     PC_Write_En,   m_pc);
    chk({tag, "_ifid"},   IFID_Write_En, m_ifid);
    chk({tag, "_bubble"}, IDEXE_Bubble,  m_bub);
    chk({tag, "_stall"},  Stall,         !m_pc);
`ifdef HAZARD_STATS_EN
    chk({tag, "_scyc"},   Stall_Cycles,    m_cycles);
    chk({tag, "_events"}, Load_Use_Events, m_events);
`else
    chk({tag, "_scyc"},   Stall_Cycles,    32'd0);
    chk({tag, "_events"}, Load_Use_Events, 32'd0);
`endif
    if (Stall) ep_stalls++;
    @(posedge CLK);
    if (RESET) model_advance();
    #1;
  endtask

  task automatic set_instr(input logic v, input int rs, input logic urs, input int rt,
                           input logic urt, input logic br, input logic rw,
                           input int dest, input logic ld);
    ID_Valid = v;
    ID_rs = RW'(rs); ID_uses_rs = urs;
    ID_rt = RW'(rt); ID_uses_rt = urt;
    ID_branch = br; ID_reg_write = rw;
    ID_dest = RW'(dest); ID_load = ld;
  endtask

  task automatic nop();      set_instr(1, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic lw(input int d); set_instr(1, 29, 1, 0, 0, 0, 1, d, 1); endtask
  task automatic beq(input int a, input int b); set_instr(1, a, 1, b, 1, 1, 0, 0, 0); endtask

  // Run one ID instruction to completion: repeat the cycle while it is held.
  task automatic issue(input string tag);
    int guard = 0;
    cycle(tag);
    while (!m_pc && guard < 4) begin
      cycle(tag);
      guard++;
    end
    chk({tag, "_bounded"}, (guard < 4), 1'b1);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_pc", PC_Write_En, 1'b1);
    chk("rst_ifid", IFID_Write_En, 1'b1);
    chk("rst_bubble", IDEXE_Bubble, 1'b0);
    chk("rst_stall", Stall, 1'b0);
    @(posedge CLK); #1;
    RESET = 1'b1;
    model_reset();

    // 1: lw $8 ; add $9,$8,$10 -> one stall cycle
    lw(8); issue("t1_lw");
    ep_stalls = 0;
    set_instr(1, 8, 1, 10, 1, 0, 1, 9, 0); issue("t1_add");
    chk("t1_stall_len", ep_stalls, 1);
`ifdef HAZARD_STATS_EN
    chk("t1_events", Load_Use_Events, 1);
`endif

    // 2: lw $8 ; beq $8,$0 -> two stall cycles
    nop(); issue("t2_pad"); issue("t2_pad2");
    lw(8); issue("t2_lw");
    ep_stalls = 0;
    beq(8, 0); issue("t2_beq");
    chk("t2_stall_len", ep_stalls, 2);

    // 3: add $8 ; beq $8,$9 -> one stall; addi $0 ; beq $0 -> none
    set_instr(1, 1, 1, 2, 1, 0, 1, 8, 0); issue("t3_add");
    ep_stalls = 0;
    beq(8, 9); issue("t3_beq");
    chk("t3_stall_len", ep_stalls, 1);
    set_instr(1, 1, 1, 0, 0, 0, 1, 0, 0); issue("t3_addi0");
    ep_stalls = 0;
    beq(0, 0); issue("t3_beq0");
    chk("t3_zero_len", ep_stalls, 0);

    // 4: lw $8 ; nop ; beq $8 -> one stall; with two nops -> none
    lw(8); issue("t4_lw");
    nop(); issue("t4_nop");
    ep_stalls = 0;
    beq(8, 0); issue("t4_beq");
    chk("t4_stall_len", ep_stalls, 1);
    lw(8); issue("t4_lw2");
    nop(); issue("t4_nop2"); issue("t4_nop3");
    ep_stalls = 0;
    beq(8, 0); issue("t4_beq2");
    chk("t4_zero_len", ep_stalls, 0);

    // 5: load/branch hazard squashed by FLUSH: bubble, no stall, stays RUN
    lw(8); issue("t5_lw");
    beq(8, 0); FLUSH = 1'b1;
    #4;
    chk("t5_bubble", IDEXE_Bubble, 1'b1);
    chk("t5_pc", PC_Write_En, 1'b1);
    #(-0); #0;
    #(1); @(posedge CLK); #1;
    model_outputs(); model_advance();
    FLUSH = 1'b0;
    ep_stalls = 0;
    nop(); issue("t5_after");
    chk("t5_run_len", ep_stalls, 0);

    // 6: reset during the second cycle of a two-cycle stall
    lw(8); issue("t6_lw");
    beq(8, 0); cycle("t6_first");
    #2; RESET = 1'b0; #1;
    chk("t6_rst_pc", PC_Write_En, 1'b1);
    chk("t6_rst_ifid", IFID_Write_En, 1'b1);
    chk("t6_rst_bubble", IDEXE_Bubble, 1'b0);
    chk("t6_rst_stall", Stall, 1'b0);
    @(posedge CLK); #1;
    RESET = 1'b1;
    model_reset();
    ep_stalls = 0;
    beq(8, 0); issue("t6_after");
    chk("t6_after_len", ep_stalls, 0);

    // Randomized streams; a stalled instruction is held in ID like real IF/ID.
    nop();
    for (int i = 0; i < 400; i++) begin
      if (m_pc) begin
        set_instr($urandom_range(0, 7) != 0,
                  $urandom_range(0, 3), $urandom_range(0, 1) != 0,
                  $urandom_range(0, 3), $urandom_range(0, 1) != 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 3), $urandom_range(0, 1) != 0);
        FLUSH = ($urandom_range(0, 7) == 0);
      end else begin
        FLUSH = 1'b0;
      end
      cycle("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
